gencon: RTL and testbench

- Controller and datapath for a 16-bit signed keypad calculator.
- Takes two decimal operands entered digit by digit, each with an optional sign, plus an operator (add, subtract or multiply).
- When equal is pressed it computes the result, then presents it in sign-magnitude form and returns to operand entry.
- Sits between the keypad/button debouncers and the display driver; it exports its FSM state for the bench.

---
 rtl/gencon.sv | 225 ++++++++++++++++++++++
 tb/tb_gencon.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gencon.sv
`default_nettype none
// ============================================================================
//  Module   : gencon
//  Purpose  : Keypad calculator controller and datapath. Two signed decimal
//             operands are entered digit by digit, combined with add,
//             subtract or multiply, and the result is shown in
//             sign-magnitude form.
//  Revision : 1.0  initial release
// ============================================================================
module gencon (
    input  logic        clk,
    input  logic        nRST,
    input  logic [3:0]  keypad_input,
    input  logic        read_input,
    input  logic [2:0]  operator_input,
    input  logic        equal_input,
    output logic        complete,
    output logic [15:0] display_output,
    output logic [2:0]  tb_current_state
);

    // FSM state codes
    localparam logic [2:0] c_ENTER_A    = 3'd0;
    localparam logic [2:0] c_OP_LATCHED = 3'd1;
    localparam logic [2:0] c_DIGIT      = 3'd2;
    localparam logic [2:0] c_ENTER_B    = 3'd3;
    localparam logic [2:0] c_COMPUTE    = 3'd4;
    localparam logic [2:0] c_DONE       = 3'd5;

    // Operator codes
    localparam logic [2:0] c_OP_NEG = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;

    localparam logic [14:0] c_MAG_MAX  = 15'h7FFF;
    localparam logic [18:0] c_MAG_LIM  = 19'd32767;
    localparam logic [31:0] c_RES_LIM  = 32'd32767;
    localparam logic [3:0]  c_MUL_LAST = 4'd14;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [14:0] r_mag_a;
    logic [14:0] r_mag_b;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [2:0]  r_op;
    logic        r_in_b;       // set once the operator is latched: B is the live operand
    logic        r_read_prev;
    logic        r_oper_prev;  // operator_input was nonzero last cycle
    logic        r_complete;
    logic [15:0] r_result;     // formatted sign-magnitude result
    logic [31:0] r_acc;        // multiply magnitude accumulator
    logic [3:0]  r_cnt;        // multiply bit index into mag_b

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic w_digit_edge;
    logic w_sign_edge;
    logic w_op_valid;
    logic w_is_b_entry;

    assign w_digit_edge = read_input & ~r_read_prev & (keypad_input <= 4'd9);
    assign w_sign_edge  = (operator_input == c_OP_NEG) & ~r_oper_prev;
    assign w_op_valid   = (operator_input == c_OP_ADD) |
                          (operator_input == c_OP_SUB) |
                          (operator_input == c_OP_MUL);
    assign w_is_b_entry = (r_state == c_ENTER_B);

    // ------------------------------------------------------------------
    // Digit accumulation: mag*10 + digit, saturated to 15 bits
    // ------------------------------------------------------------------
    logic [14:0] w_cur_mag;
    logic [18:0] w_mag_ext;
    logic [18:0] w_mag_calc;
    logic [14:0] w_mag_sat;

    assign w_cur_mag  = w_is_b_entry ? r_mag_b : r_mag_a;
    assign w_mag_ext  = {4'd0, w_cur_mag};
    assign w_mag_calc = (w_mag_ext << 3) + (w_mag_ext << 1) + {15'd0, keypad_input};
    assign w_mag_sat  = (w_mag_calc > c_MAG_LIM) ? c_MAG_MAX : w_mag_calc[14:0];

    // ------------------------------------------------------------------
    // Arithmetic in 32-bit two's complement
    // ------------------------------------------------------------------
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [31:0] w_a_tc;
    logic [31:0] w_b_tc;
    logic [31:0] w_addsub;
    logic [31:0] w_pp;
    logic [31:0] w_acc_next;
    logic [31:0] w_mul_tc;
    logic [31:0] w_raw;

    assign w_a_abs  = {17'd0, r_mag_a};
    assign w_b_abs  = {17'd0, r_mag_b};
    assign w_a_tc   = r_sign_a ? (32'd0 - w_a_abs) : w_a_abs;
    assign w_b_tc   = r_sign_b ? (32'd0 - w_b_abs) : w_b_abs;
    assign w_addsub = (r_op == c_OP_SUB) ? (w_a_tc - w_b_tc) : (w_a_tc + w_b_tc);

    // One partial product per cycle; the sign is applied only to the final sum
    assign w_pp       = r_mag_b[r_cnt] ? (w_a_abs << r_cnt) : 32'd0;
    assign w_acc_next = r_acc + w_pp;
    assign w_mul_tc   = (r_sign_a ^ r_sign_b) ? (32'd0 - w_acc_next) : w_acc_next;

    assign w_raw = (r_op == c_OP_MUL) ? w_mul_tc : w_addsub;

    // ------------------------------------------------------------------
    // Result formatting: clamp to +/-32767, sign-magnitude, zero is +0
    // ------------------------------------------------------------------
    logic        w_raw_neg;
    logic [31:0] w_raw_abs;
    logic [15:0] w_fmt;

    assign w_raw_neg = w_raw[31];
    assign w_raw_abs = w_raw_neg ? (32'd0 - w_raw) : w_raw;
    assign w_fmt     = (w_raw_abs > c_RES_LIM) ? {w_raw_neg, c_MAG_MAX}
                                               : {w_raw_neg, w_raw_abs[14:0]};

    // Edge-detect history for the digit strobe and operator keys
    always_ff @(posedge clk) begin
        if (nRST) begin
            r_read_prev <= 1'b0;
            r_oper_prev <= 1'b0;
        end else begin
            r_read_prev <= read_input;
            r_oper_prev <= (operator_input != 3'd0);
        end
    end

    // Main controller: operand entry, operator latch, compute and completion
    always_ff @(posedge clk) begin
        if (nRST) begin
            r_state    <= c_ENTER_A;
            r_mag_a    <= 15'd0;
            r_mag_b    <= 15'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_op       <= 3'd0;
            r_in_b     <= 1'b0;
            r_complete <= 1'b0;
            r_result   <= 16'd0;
            r_acc      <= 32'd0;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                c_ENTER_A, c_ENTER_B: begin
                    if (w_digit_edge) begin
                        if (w_is_b_entry) begin
                            r_mag_b <= w_mag_sat;
                        end else begin
                            r_mag_a <= w_mag_sat;
                        end
                        r_complete <= 1'b0;
                        r_state    <= c_DIGIT;
                    end else if (w_sign_edge) begin
                        if (w_is_b_entry) begin
                            r_sign_b <= ~r_sign_b;
                        end else begin
                            r_sign_a <= ~r_sign_a;
                        end
                        r_complete <= 1'b0;
                    end else if (!w_is_b_entry && w_op_valid) begin
                        r_op     <= operator_input;
                        r_mag_b  <= 15'd0;
                        r_sign_b <= 1'b0;
                        r_in_b   <= 1'b1;
                        r_state  <= c_OP_LATCHED;
                    end else if (w_is_b_entry && equal_input) begin
                        r_acc   <= 32'd0;
                        r_cnt   <= 4'd0;
                        r_state <= c_COMPUTE;
                    end
                end

                c_OP_LATCHED: begin
                    r_state <= c_ENTER_B;
                end

                c_DIGIT: begin
                    r_state <= r_in_b ? c_ENTER_B : c_ENTER_A;
                end

                c_COMPUTE: begin
                    if ((r_op == c_OP_MUL) && (r_cnt != c_MUL_LAST)) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_result   <= w_fmt;
                        r_complete <= 1'b1;
                        r_state    <= c_DONE;
                    end
                end

                c_DONE: begin
                    r_mag_a  <= 15'd0;
                    r_mag_b  <= 15'd0;
                    r_sign_a <= 1'b0;
                    r_sign_b <= 1'b0;
                    r_op     <= 3'd0;
                    r_in_b   <= 1'b0;
                    r_acc    <= 32'd0;
                    r_cnt    <= 4'd0;
                    r_state  <= c_ENTER_A;
                end

                default: begin
                    r_state <= c_ENTER_A;
                end
            endcase
        end
    end

    // A held result takes precedence; otherwise show the operand being entered
    assign display_output   = r_complete ? r_result
                                         : (r_in_b ? {r_sign_b, r_mag_b} : {r_sign_a, r_mag_a});
    assign complete         = r_complete;
    assign tb_current_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gencon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gencon
//  Purpose  : Self-checking bench for gencon: directed calculations, keypad
//             handshake corners, reset during multiply and randomized
//             calculations against an integer arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gencon;

    logic        clk = 1'b0;
    logic        nRST = 1'b1;
    logic [3:0]  keypad_input = 4'd0;
    logic        read_input = 1'b0;
    logic [2:0]  operator_input = 3'd0;
    logic        equal_input = 1'b0;
    logic        complete;
    logic [15:0] display_output;
    logic [2:0]  tb_current_state;

    int n_checks = 0;
    int n_err    = 0;

    gencon dut (
        .clk              (clk),
        .nRST             (nRST),
        .keypad_input     (keypad_input),
        .read_input       (read_input),
        .operator_input   (operator_input),
        .equal_input      (equal_input),
        .complete         (complete),
        .display_output   (display_output),
        .tb_current_state (tb_current_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Calculator semantics in plain integer arithmetic
    function automatic logic [15:0] model(input bit na, input int ma, input int op,
                                          input bit nb, input int mb);
        int a, b, r, m;
        a = na ? -ma : ma;
        b = nb ? -mb : mb;
        if (op == 2)      r = a + b;
        else if (op == 3) r = a - b;
        else              r = a * b;
        if (r > 32767)  r = 32767;
        if (r < -32767) r = -32767;
        m = (r < 0) ? -r : r;
        return {(r < 0), m[14:0]};
    endfunction

    function automatic logic [15:0] sm(input bit neg, input int mag);
        return {neg, mag[14:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk) nRST = 1'b1;
        @(negedge clk) nRST = 1'b0;
    endtask

    task automatic press_digit(input int d, input int hold);
        @(negedge clk) keypad_input = 4'(d);
        @(negedge clk) read_input = 1'b1;
        repeat (hold) @(negedge clk);
        read_input = 1'b0;
    endtask

    task automatic op_pulse(input logic [2:0] code);
        @(negedge clk) operator_input = code;
        @(negedge clk) operator_input = 3'd0;
    endtask

    // Enters an optional sign then the decimal digits of v; returns the
    // magnitude the calculator should hold (saturating at 32767)
    task automatic enter_operand(input bit neg, input int v, output int mag);
        int digs[$];
        int t;
        t = v;
        digs.delete();
        if (t == 0) digs.push_front(0);
        while (t > 0) begin
            digs.push_front(t % 10);
            t = t / 10;
        end
        if (neg) op_pulse(3'b001);
        mag = 0;
        foreach (digs[k]) begin
            press_digit(digs[k], 1);
            mag = mag * 10 + digs[k];
            if (mag > 32767) mag = 32767;
        end
        @(negedge clk);
    endtask

    task automatic do_calc(input string tag, input bit na, input int va, input logic [2:0] op,
                           input bit nb, input int vb, input bit keep_equal);
        int ma, mb, ccount;
        bit done;
        logic [15:0] exp;
        enter_operand(na, va, ma);
        check({tag, " A display"}, display_output, sm(na, ma));
        op_pulse(op);
        check({tag, " op state"}, tb_current_state, 3'd1);
        check({tag, " op display"}, display_output, 16'd0);
        enter_operand(nb, vb, mb);
        check({tag, " B display"}, display_output, sm(nb, mb));
        exp = model(na, ma, int'(op), nb, mb);
        @(negedge clk) equal_input = 1'b1;
        ccount = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (tb_current_state == 3'd4) ccount++;
            else if (tb_current_state == 3'd5) done = 1'b1;
        end
        check({tag, " reached DONE"}, 32'(done), 32'd1);
        check({tag, " compute cycles"}, ccount, (op == 3'b100) ? 15 : 1);
        check({tag, " complete"}, 32'(complete), 32'd1);
        check({tag, " result"}, display_output, exp);
        if (!keep_equal) equal_input = 1'b0;
        @(negedge clk);
        check({tag, " back to A"}, tb_current_state, 3'd0);
        check({tag, " held complete"}, 32'(complete), 32'd1);
        check({tag, " held result"}, display_output, exp);
    endtask

    initial begin
        int m;
        bit na, nb;
        int va, vb, cls;
        logic [2:0] op;

        do_reset();
        check("reset state", tb_current_state, 3'd0);
        check("reset complete", 32'(complete), 32'd0);
        check("reset display", display_output, 16'd0);

        // Directed calculations
        do_calc("4x3",        0, 4,     3'b100, 0, 3,    0);
        do_calc("-3x-6",      1, 3,     3'b100, 1, 6,    0);
        do_calc("-2x5",       1, 2,     3'b100, 0, 5,    0);
        do_calc("181x181",    0, 181,   3'b100, 0, 181,  0);
        do_calc("1234+-5678", 0, 1234,  3'b010, 1, 5678, 0);
        do_calc("-999-999",   1, 999,   3'b011, 0, 999,  0);
        do_calc("1-1",        0, 1,     3'b011, 0, 1,    0);
        do_calc("32766--1",   0, 32766, 3'b011, 1, 1,    0);
        do_calc("32767+1",    0, 32767, 3'b010, 0, 1,    0);
        do_calc("-32767x1",   1, 32767, 3'b100, 0, 1,    0);
        do_calc("99999+0",    0, 99999, 3'b010, 0, 0,    0);
        check("4x3 literal", model(0, 4, 4, 0, 3), 16'h000C);

        // Equal held high after a result must not start another computation
        do_calc("eqhold", 0, 9, 3'b010, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("eqhold idle state", tb_current_state, 3'd0);
            check("eqhold complete", 32'(complete), 32'd1);
        end
        equal_input = 1'b0;

        // Strobe held for three cycles enters one digit and clears complete
        press_digit(7, 3);
        @(negedge clk);
        check("hold3 complete cleared", 32'(complete), 32'd0);
        check("hold3 display", display_output, 16'h0007);
        check("hold3 state", tb_current_state, 3'd0);
        press_digit(2, 1);
        @(negedge clk);
        check("hold3 next digit", display_output, 16'd72);

        // Reset in the middle of a multiply
        op_pulse(3'b100);
        enter_operand(0, 5, m);
        @(negedge clk) equal_input = 1'b1;
        repeat (5) @(negedge clk);
        check("mul in progress", tb_current_state, 3'd4);
        nRST = 1'b1;
        @(negedge clk);
        check("midreset state", tb_current_state, 3'd0);
        check("midreset complete", 32'(complete), 32'd0);
        check("midreset display", display_output, 16'd0);
        nRST = 1'b0;
        equal_input = 1'b0;
        @(negedge clk);
        check("post reset state", tb_current_state, 3'd0);

        // Randomized calculations against the integer model
        for (int i = 0; i < 12; i++) begin
            na  = 1'($urandom_range(0, 1));
            nb  = 1'($urandom_range(0, 1));
            cls = $urandom_range(0, 2);
            va  = (cls == 0) ? $urandom_range(0, 99) : (cls == 1) ? $urandom_range(0, 9999)
                                                                  : $urandom_range(0, 99999);
            cls = $urandom_range(0, 2);
            vb  = (cls == 0) ? $urandom_range(0, 99) : (cls == 1) ? $urandom_range(0, 9999)
                                                                  : $urandom_range(0, 99999);
            op  = 3'($urandom_range(2, 4));
            do_calc($sformatf("rnd%0d", i), na, va, op, nb, vb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
